multi_channel_data_generator: RTL

Parametrised successor of the single-channel read-handshake counter. Provides NUM_CH independent data channels. Each channel advances once per rising edge of its own read strobe. Global modes: count up, count down, Galois LFSR, or hold. Adds synchronous load, per-channel advance pulses and sticky wrap flags; sits in front of the consumer/DMA test path as a stimulus source.

---
 rtl/data_gen_pkg.sv | 26 ++
 rtl/multi_channel_data_generator_if.sv | 35 +++
 rtl/data_gen_channel.sv | 113 +++++++++++
 rtl/multi_channel_data_generator.sv | 56 +++++
 4 files changed

// File: rtl/data_gen_pkg.sv
// +--------------------------------------------------------------------------+
// | data_gen_pkg : shared mode/state encodings for the channel generator.     |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

package data_gen_pkg;

  typedef enum logic [1:0] {
    COUNT_UP   = 2'd0,
    COUNT_DOWN = 2'd1,
    LFSR       = 2'd2,
    HOLD       = 2'd3
  } mode_e;

  typedef enum logic {
    WAIT_HIGH = 1'b0,
    WAIT_LOW  = 1'b1
  } ch_state_e;

  // x^32 + x^22 + x^2 + x + 1, Galois form
  localparam logic [31:0] DEFAULT_LFSR_POLY = 32'h8020_0003;

endpackage

`default_nettype wire

// File: rtl/multi_channel_data_generator_if.sv
// +--------------------------------------------------------------------------+
// | multi_channel_data_generator_if : control/data bundle of the generator.   |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

interface multi_channel_data_generator_if #(
  parameter int DATA_W = 32,
  parameter int NUM_CH = 4
) ();
  import data_gen_pkg::*;

  logic                     enable;
  logic [NUM_CH-1:0]        read;
  mode_e                    mode;
  logic                     load;
  logic [DATA_W-1:0]        load_value;
  logic [NUM_CH-1:0]        wrap_clr;
  logic [NUM_CH*DATA_W-1:0] data;
  logic [NUM_CH-1:0]        advanced;
  logic [NUM_CH-1:0]        wrap;

  modport master (
    output enable, read, mode, load, load_value, wrap_clr,
    input  data, advanced, wrap
  );

  modport slave (
    input  enable, read, mode, load, load_value, wrap_clr,
    output data, advanced, wrap
  );

endinterface

`default_nettype wire

// File: rtl/data_gen_channel.sv
// +--------------------------------------------------------------------------+
// | data_gen_channel : one read-handshake FSM with its data word and flags.   |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

module data_gen_channel
  import data_gen_pkg::*;
#(
  parameter int                DATA_W    = 32,
  parameter int                STEP      = 1,
  parameter logic [DATA_W-1:0] LFSR_POLY = DATA_W'(DEFAULT_LFSR_POLY)
) (
  input  wire logic              clock,
  input  wire logic              srst,
  input  wire logic              enable,
  input  wire logic              read,
  input  wire mode_e             mode,
  input  wire logic              load,
  input  wire logic [DATA_W-1:0] load_value,
  input  wire logic              wrap_clr,
  output logic      [DATA_W-1:0] data,
  output logic                   advanced,
  output logic                   wrap
);

  localparam logic [DATA_W-1:0] STEP_W = DATA_W'(STEP);

  ch_state_e         state;
  ch_state_e         state_next;
  logic              adv_req;
  logic [DATA_W:0]   up_sum;
  logic [DATA_W-1:0] adv_value;
  logic              adv_wrap;

  always_ff @(posedge clock) begin
    if (srst) begin
      state <= WAIT_HIGH;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    adv_req    = 1'b0;
    if (enable) begin
      case (state)
        WAIT_HIGH: begin
          if (read) begin
            state_next = WAIT_LOW;
            adv_req    = 1'b1;
          end
        end
        WAIT_LOW: begin
          if (!read) begin
            state_next = WAIT_HIGH;
          end
        end
        default: state_next = WAIT_HIGH;
      endcase
    end
  end

  assign up_sum = {1'b0, data} + {1'b0, STEP_W};

  always_comb begin
    adv_value = data;
    adv_wrap  = 1'b0;
    case (mode)
      COUNT_UP: begin
        adv_value = up_sum[DATA_W-1:0];
        adv_wrap  = up_sum[DATA_W];
      end
      COUNT_DOWN: begin
        adv_value = data - STEP_W;
        adv_wrap  = (data < STEP_W);
      end
      LFSR: begin
        // An all-zero register would never leave zero, so kick it to 1
        if (data == '0) begin
          adv_value = {{(DATA_W-1){1'b0}}, 1'b1};
        end else begin
          adv_value = (data >> 1) ^ (data[0] ? LFSR_POLY : '0);
        end
      end
      default: adv_value = data;
    endcase
  end

  always_ff @(posedge clock) begin
    if (srst) begin
      data     <= '0;
      advanced <= 1'b0;
      wrap     <= 1'b0;
    end else begin
      advanced <= adv_req && !load;
      if (load) begin
        data <= load_value;
      end else if (adv_req) begin
        data <= adv_value;
      end
      if (adv_req && !load && adv_wrap) begin
        wrap <= 1'b1;
      end else if (enable && wrap_clr) begin
        wrap <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/multi_channel_data_generator.sv
// +--------------------------------------------------------------------------+
// | multi_channel_data_generator : NUM_CH independent handshake data sources. |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

module multi_channel_data_generator
  import data_gen_pkg::*;
#(
  parameter int                DATA_W    = 32,
  parameter int                NUM_CH    = 4,
  parameter int                STEP      = 1,
  parameter logic [DATA_W-1:0] LFSR_POLY = DATA_W'(DEFAULT_LFSR_POLY)
) (
  input wire logic                  clock,
  input wire logic                  srst,
  multi_channel_data_generator_if.slave bus
);

  logic [DATA_W-1:0] ch_data [NUM_CH];
  logic [NUM_CH-1:0] ch_adv;
  logic [NUM_CH-1:0] ch_wrap;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    data_gen_channel #(
      .DATA_W    (DATA_W),
      .STEP      (STEP),
      .LFSR_POLY (LFSR_POLY)
    ) u_channel (
      .clock      (clock),
      .srst       (srst),
      .enable     (bus.enable),
      .read       (bus.read[c]),
      .mode       (bus.mode),
      .load       (bus.load),
      .load_value (bus.load_value),
      .wrap_clr   (bus.wrap_clr[c]),
      .data       (ch_data[c]),
      .advanced   (ch_adv[c]),
      .wrap       (ch_wrap[c])
    );
  end

  always_comb begin
    bus.data = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      bus.data[c*DATA_W +: DATA_W] = ch_data[c];
    end
  end

  assign bus.advanced = ch_adv;
  assign bus.wrap     = ch_wrap;

endmodule

`default_nettype wire
